feature_map_collector: RTL and testbench



---
 rtl/feature_map_collector_pkg.sv | 26 ++
 rtl/feature_map_collector_frame_buffer_ram.sv | 30 +++
 rtl/feature_map_collector.sv | 169 ++++++++++++++++
 tb/tb_feature_map_collector.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/feature_map_collector_pkg.sv
// Shared types and size helpers for the feature map collector.
package feature_map_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  function automatic int calc_groups(input int num_k, input int pe);
    return num_k / pe;
  endfunction

  function automatic int calc_pixels(input int out_width);
    return out_width * out_width;
  endfunction

  function automatic int calc_frame(input int num_k, input int out_width);
    return num_k * out_width * out_width;
  endfunction

  // Never narrower than one bit, so single-entry counters still get a register.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feature_map_collector_frame_buffer_ram.sv
// Frame buffer: multi-lane strided write port, one combinational read port.
module feature_map_collector_frame_buffer_ram #(
  parameter int BitSize            = 4,
  parameter int ProcessingElements = 2,
  parameter int Pixels             = 4,
  parameter int Depth              = 32,
  parameter int AddrW              = 5
) (
  input  logic                                   clk,
  input  logic                                   we_i,
  input  logic [AddrW-1:0]                       base_i,
  input  logic [ProcessingElements*BitSize-1:0]  wdata_i,
  input  logic [AddrW-1:0]                       raddr_i,
  output logic [BitSize-1:0]                     rdata_o
);

  logic [BitSize-1:0] mem_q [Depth];

  // Lane j lands one feature map (Pixels entries) after lane j-1.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int j = 0; j < ProcessingElements; j++) begin
        mem_q[base_i + AddrW'(j * Pixels)] <= wdata_i[j*BitSize +: BitSize];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/feature_map_collector.sv
// Collects a conv-stage output frame and replays it kernel-major on a single lane.
// Optional COLLECTOR_ERR_EN adds a sticky err output for mask/protocol violations.
module feature_map_collector
  import feature_map_collector_pkg::*;
#(
  parameter int BitSize            = 4,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2,
  parameter int OutWidth           = 2
) (
  input  logic                                  clk,
  input  logic                                  res_n,
  input  logic [NumberOfK-1:0]                  in_valid,
  input  logic [ProcessingElements*BitSize-1:0] in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [BitSize-1:0]                    out_data,
  output logic                                  out_last,
  input  logic                                  out_ready,
  output logic                                  frame_done
`ifdef COLLECTOR_ERR_EN
  ,
  output logic                                  err
`endif
);

  localparam int G  = calc_groups(NumberOfK, ProcessingElements);
  localparam int P  = calc_pixels(OutWidth);
  localparam int F  = calc_frame(NumberOfK, OutWidth);
  localparam int AW = addr_width(F);
  localparam int GW = addr_width(G);
  localparam int PW = addr_width(P);

  localparam logic [GW-1:0] GRP_LAST = GW'(G - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(P - 1);
  localparam logic [AW-1:0] RD_LAST  = AW'(F - 1);

  state_e        state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          beat_acc_s;
  logic          xfer_s;
  logic          we_s;
  logic [AW-1:0] wr_base_s;
  logic [BitSize-1:0] rd_data_s;

  assign in_ready   = (state_q == COLLECT);
  assign out_valid  = (state_q == DRAIN);
  assign out_last   = out_valid && (rd_q == RD_LAST);
  assign out_data   = out_valid ? rd_data_s : '0;
  assign frame_done = out_valid && out_ready && out_last;
  assign beat_acc_s = (|in_valid) && in_ready;
  assign xfer_s     = out_valid && out_ready;
  // First kernel of the group is grp*PE, so its map starts grp*PE*P entries in.
  assign wr_base_s  = AW'(grp_q) * AW'(ProcessingElements * P) + AW'(pix_q);

  feature_map_collector_frame_buffer_ram #(
    .BitSize            (BitSize),
    .ProcessingElements (ProcessingElements),
    .Pixels             (P),
    .Depth              (F),
    .AddrW              (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (we_s),
    .base_i  (wr_base_s),
    .wdata_i (in_data),
    .raddr_i (rd_q),
    .rdata_o (rd_data_s)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= COLLECT;
      grp_q   <= '0;
      pix_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      pix_q   <= pix_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic for collect counters and replay pointer.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    pix_d   = pix_q;
    rd_d    = rd_q;
    we_s    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (beat_acc_s) begin
          we_s = 1'b1;
          if (grp_q == GRP_LAST) begin
            grp_d = '0;
            if (pix_q == PIX_LAST) begin
              pix_d   = '0;
              rd_d    = '0;
              state_d = DRAIN;
            end else begin
              pix_d = pix_q + PW'(1);
            end
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end else begin
          we_s = 1'b0;
        end
      end
      DRAIN: begin
        if (xfer_s) begin
          if (rd_q == RD_LAST) begin
            rd_d    = '0;
            grp_d   = '0;
            pix_d   = '0;
            state_d = COLLECT;
          end else begin
            rd_d = rd_q + AW'(1);
          end
        end else begin
          rd_d = rd_q;
        end
      end
      default: begin
        state_d = COLLECT;
        grp_d   = '0;
        pix_d   = '0;
        rd_d    = '0;
      end
    endcase
  end

`ifdef COLLECTOR_ERR_EN
  localparam logic [NumberOfK-1:0] LANE_ONES = NumberOfK'((1 << ProcessingElements) - 1);

  logic                 err_q, err_d;
  logic [NumberOfK-1:0] exp_mask_s;

  // Sticky error: wrong mask on an accepted beat, or data offered while stalled.
  always_comb begin
    exp_mask_s = LANE_ONES << (int'(grp_q) * ProcessingElements);
    err_d      = err_q;
    if (beat_acc_s && (in_valid != exp_mask_s)) begin
      err_d = 1'b1;
    end else if ((|in_valid) && !in_ready) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_feature_map_collector.sv
// Scoreboard bench for feature_map_collector: frames in, kernel-major replay checked.
module tb_feature_map_collector;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       frame_done;
`ifdef COLLECTOR_ERR_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q [$];

  feature_map_collector dut (
    .clk        (clk),
    .res_n      (res_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_done (frame_done)
`ifdef COLLECTOR_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pix_val(input int k, input int p, input int off);
    return 4'((k + p + off) & 15);
  endfunction

  // Drives one frame in group order and queues its expected kernel-major replay.
  task automatic drive_frame(input int off, input logic [7:0] first_mask);
    logic       lst;
    logic [7:0] mask;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) begin
        lst = (k == 7) && (p == 3);
        exp_q.push_back({lst, pix_val(k, p, off)});
      end
    end
    for (int p = 0; p < 4; p++) begin
      for (int g = 0; g < 4; g++) begin
        check_eq("in_ready_collect", {31'd0, in_ready}, 32'd1);
        mask = 8'(3 << (g * 2));
        if ((p == 0) && (g == 0) && (first_mask != 8'h00)) begin
          mask = first_mask;
        end
        in_valid = mask;
        in_data  = {pix_val(2*g + 1, p, off), pix_val(2*g, p, off)};
        @(posedge clk);
        #1;
        check_eq("valid_rise", {31'd0, out_valid}, ((p == 3) && (g == 3)) ? 32'd1 : 32'd0);
`ifdef COLLECTOR_ERR_EN
        if ((p == 0) && (g == 0) && (first_mask != 8'h00)) begin
          check_eq("err_set", {31'd0, err}, 32'd1);
        end
`endif
      end
    end
    in_valid = 8'h00;
    in_data  = 8'h00;
  endtask

  // Drains one frame; mode 1 = out_ready toggling starting low.
  task automatic drain(input int mode, input int inject_at, input int reset_at, input int exp_cycles);
    int         cyc  = 0;
    int         idx  = 0;
    bit         done = 1'b0;
    logic [4:0] e;
    while (!done && (cyc < 300)) begin
      out_ready = (mode == 1) ? cyc[0] : 1'b1;
      if ((idx == inject_at) && out_valid) begin
        in_valid = 8'h03;
        in_data  = 8'hFF;
      end else begin
        in_valid = 8'h00;
        in_data  = 8'h00;
      end
      if (idx == reset_at) begin
        res_n = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        exp_q.delete();
        #1;
        res_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      #1;
      if (idx == inject_at) begin
        check_eq("in_ready_drain", {31'd0, in_ready}, 32'd0);
      end
      check_eq("drain_valid", {31'd0, out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("queue_empty", 32'd0, 32'd1);
        done = 1'b1;
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check_eq("out_data", {28'd0, out_data}, {28'd0, e[3:0]});
        check_eq("out_last", {31'd0, out_last}, {31'd0, e[4]});
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, e[4]});
        idx++;
        done = e[4];
      end else begin
        e = exp_q[0];
        check_eq("stall_data", {28'd0, out_data}, {28'd0, e[3:0]});
        check_eq("stall_done", {31'd0, frame_done}, 32'd0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 8'h00;
    if (!done) begin
      check_eq("drain_timeout", 32'd0, 32'd1);
    end
    check_eq("drain_cycles", 32'(cyc), 32'(exp_cycles));
    check_eq("post_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_out_last", {31'd0, out_last}, 32'd0);
  endtask

  initial begin
    res_n     = 1'b0;
    in_valid  = 8'h00;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_out_last", {31'd0, out_last}, 32'd0);
    check_eq("reset_out_data", {28'd0, out_data}, 32'd0);
    check_eq("reset_frame_done", {31'd0, frame_done}, 32'd0);
    res_n = 1'b1;
    @(posedge clk);
    #1;

    drive_frame(0, 8'h00);
    drain(0, -1, -1, 32);
    drive_frame(0, 8'h00);
    drain(1, -1, -1, 64);
    drive_frame(0, 8'h00);
    drain(0, 5, -1, 32);
    drive_frame(8, 8'h00);
    drain(0, -1, -1, 32);
    drive_frame(3, 8'h00);
    drain(0, -1, 10, 32);
    drive_frame(5, 8'h00);
    drain(0, -1, -1, 32);

`ifdef COLLECTOR_ERR_EN
    res_n = 1'b0;
    #2;
    res_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("err_reset", {31'd0, err}, 32'd0);
    drive_frame(0, 8'h0C);
    drain(0, -1, -1, 32);
    check_eq("err_sticky", {31'd0, err}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
